// File: rtl/xm_decode_stage_if.sv
// Fetch-to-execute bus of the XMakina decode stage.
// The stage uses the slave view; its environment uses master.
interface xm_decode_stage_if #(
    parameter int WORD   = 16,
    parameter int FLAG_W = 4
);
    logic [WORD-1:0]   inst_i;
    logic              inst_valid_i;
    logic              inst_ready_o;
    logic [FLAG_W-1:0] flags_i;
    logic              flush_i;
    logic              dec_valid_o;
    logic              dec_ready_i;
    logic [WORD-1:0]   inst_o;
    logic [4:0]        instOp_o;
    logic [2:0]        regAdrA_o;
    logic [2:0]        regAdrB_o;
    logic              byteOp_o;
    logic              exec_o;
    logic              cexActive_o;

    modport slave (
        input  inst_i, inst_valid_i, flags_i, flush_i, dec_ready_i,
        output inst_ready_o, dec_valid_o, inst_o, instOp_o,
        output regAdrA_o, regAdrB_o, byteOp_o, exec_o, cexActive_o
    );

    modport master (
        output inst_i, inst_valid_i, flags_i, flush_i, dec_ready_i,
        input  inst_ready_o, dec_valid_o, inst_o, instOp_o,
        input  regAdrA_o, regAdrB_o, byteOp_o, exec_o, cexActive_o
    );
endinterface

// File: rtl/xm_decode_stage.sv
// XMakina registered decode stage with valid/ready flow control
// and conditional-execution block sequencing.
module xm_decode_stage #(
    parameter int WORD   = 16,
    parameter int CNT_W  = 3,
    parameter int FLAG_W = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    xm_decode_stage_if.slave bus
);
    localparam logic [4:0] OP_CBR  = 5'd2;
    localparam logic [4:0] OP_LBR  = 5'd3;
    localparam logic [4:0] OP_ALU  = 5'd4;
    localparam logic [4:0] OP_ALD  = 5'd5;
    localparam logic [4:0] OP_AST  = 5'd6;
    localparam logic [4:0] OP_RLD  = 5'd7;
    localparam logic [4:0] OP_RST  = 5'd8;
    localparam logic [4:0] OP_IMM  = 5'd9;
    localparam logic [4:0] OP_SWP  = 5'd10;
    localparam logic [4:0] OP_TRP  = 5'd11;
    localparam logic [4:0] OP_CEX  = 5'd12;

    typedef enum logic [1:0] {IDLE, TBLK, FBLK} state_t;

    function automatic logic [4:0] f_decode(input logic [WORD-1:0] w);
        logic [4:0] op;
        op = OP_ALU;
        unique case (1'b1)
            w[15:13] == 3'b000: op = OP_LBR;
            w[15:13] == 3'b001: op = OP_CBR;
            w[15:12] == 4'b0100 && w[11:8] == 4'b1100: op = OP_SWP;
            w[15:12] == 4'b0100 && w[11:8] != 4'b1100: op = OP_ALU;
            w[15:10] == 6'b010100: op = OP_ALD;
            w[15:10] == 6'b010101: op = OP_AST;
            w[15:10] == 6'b010110: op = OP_TRP;
            w[15:10] == 6'b010111: op = OP_CEX;
            w[15:13] == 3'b011: op = OP_IMM;
            w[15:14] == 2'b10: op = OP_RLD;
            w[15:14] == 2'b11: op = OP_RST;
        endcase
        return op;
    endfunction

    // flag bits are {V,N,Z,C}
    function automatic logic f_cond(input logic [3:0] c,
                                    input logic [FLAG_W-1:0] fl);
        logic v, n, z, cy, r;
        {v, n, z, cy} = fl[3:0];
        unique case (c)
            4'd0:  r = z;
            4'd1:  r = !z;
            4'd2:  r = cy;
            4'd3:  r = !cy;
            4'd4:  r = n;
            4'd5:  r = !n;
            4'd6:  r = v;
            4'd7:  r = !v;
            4'd8:  r = cy && !z;
            4'd9:  r = !cy || z;
            4'd10: r = n == v;
            4'd11: r = n != v;
            4'd12: r = !z && (n == v);
            4'd13: r = z || (n != v);
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_tcnt, w_tcnt_nxt;
    logic [CNT_W-1:0] r_fcnt, w_fcnt_nxt;
    logic             r_res, w_res_nxt;
    logic             r_valid;
    logic [WORD-1:0]  r_inst;
    logic [4:0]       r_op;
    logic             r_exec;
    logic             r_cex_act;

    logic             w_accept;
    logic [4:0]       w_op;
    logic             w_is_cex;
    logic             w_exec;
    logic [CNT_W-1:0] w_t;
    logic [CNT_W-1:0] w_f;

    assign bus.inst_ready_o = !r_valid || bus.dec_ready_i;
    assign w_accept = bus.inst_valid_i && bus.inst_ready_o;
    assign w_op     = f_decode(bus.inst_i);
    assign w_is_cex = (w_op == OP_CEX);
    assign w_t      = bus.inst_i[3+CNT_W-1:3];
    assign w_f      = bus.inst_i[CNT_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_fcnt_nxt  = r_fcnt;
        w_res_nxt   = r_res;
        w_exec      = 1'b1;
        if (w_accept) begin
            unique case (r_state)
                IDLE: begin
                    if (w_is_cex) begin
                        w_res_nxt  = f_cond(bus.inst_i[9:6], bus.flags_i);
                        w_tcnt_nxt = w_t;
                        w_fcnt_nxt = w_f;
                        if (w_t != '0)      w_state_nxt = TBLK;
                        else if (w_f != '0) w_state_nxt = FBLK;
                    end
                end
                TBLK: begin
                    // a nested CEX just occupies a slot and never runs
                    w_exec     = r_res && !w_is_cex;
                    w_tcnt_nxt = r_tcnt - CNT_W'(1);
                    if (r_tcnt == CNT_W'(1))
                        w_state_nxt = (r_fcnt != '0) ? FBLK : IDLE;
                end
                FBLK: begin
                    w_exec     = !r_res && !w_is_cex;
                    w_fcnt_nxt = r_fcnt - CNT_W'(1);
                    if (r_fcnt == CNT_W'(1))
                        w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_fcnt    <= '0;
            r_res     <= 1'b0;
            r_valid   <= 1'b0;
            r_inst    <= '0;
            r_op      <= '0;
            r_exec    <= 1'b0;
            r_cex_act <= 1'b0;
        end else if (bus.flush_i) begin
            r_state   <= IDLE;
            r_tcnt    <= '0;
            r_fcnt    <= '0;
            r_valid   <= 1'b0;
            r_cex_act <= 1'b0;
        end else if (w_accept) begin
            r_state   <= w_state_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_res     <= w_res_nxt;
            r_valid   <= 1'b1;
            r_inst    <= bus.inst_i;
            r_op      <= w_op;
            r_exec    <= w_exec;
            r_cex_act <= (w_state_nxt != IDLE);
        end else if (bus.dec_ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.dec_valid_o = r_valid;
    assign bus.inst_o      = r_inst;
    assign bus.instOp_o    = r_op;
    assign bus.regAdrA_o   = r_inst[2:0];
    assign bus.regAdrB_o   = r_inst[5:3];
    assign bus.byteOp_o    = r_inst[6];
    assign bus.exec_o      = r_exec;
    assign bus.cexActive_o = r_cex_act;
endmodule

// File: tb/tb_xm_decode_stage.sv
// Directed-vector bench for the XMakina decode stage.
// Checks handshake, opcode classes, CEX sequencing and flush.
module tb_xm_decode_stage;
    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    xm_decode_stage_if #(.WORD(16), .FLAG_W(4)) bus ();

    xm_decode_stage #(.WORD(16), .CNT_W(3), .FLAG_W(4)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present one instruction, expect it accepted and issued next cycle
    task automatic issue(input string tag, input logic [15:0] ins,
                         input logic [4:0] op, input logic ex,
                         input logic act);
        bus.inst_i       = ins;
        bus.inst_valid_i = 1'b1;
        #0;
        chk({tag, ".rdy"}, 16'(bus.inst_ready_o), 16'd1);
        @(posedge clk);
        #1;
        bus.inst_valid_i = 1'b0;
        chk({tag, ".vld"}, 16'(bus.dec_valid_o), 16'd1);
        chk({tag, ".inst"}, bus.inst_o, ins);
        chk({tag, ".op"}, 16'(bus.instOp_o), 16'(op));
        chk({tag, ".exec"}, 16'(bus.exec_o), 16'(ex));
        chk({tag, ".cex"}, 16'(bus.cexActive_o), 16'(act));
    endtask

    initial begin
        rstn             = 1'b0;
        bus.inst_i       = 16'h0;
        bus.inst_valid_i = 1'b0;
        bus.flags_i      = 4'b0000;
        bus.flush_i      = 1'b0;
        bus.dec_ready_i  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld", 16'(bus.dec_valid_o), 16'd0);
        chk("rst.inst", bus.inst_o, 16'h0);
        chk("rst.op", 16'(bus.instOp_o), 16'd0);
        chk("rst.exec", 16'(bus.exec_o), 16'd0);
        chk("rst.cex", 16'(bus.cexActive_o), 16'd0);
        chk("rst.rdy", 16'(bus.inst_ready_o), 16'd1);
        rstn = 1'b1;

        issue("swap", 16'h4C0A, 5'd10, 1'b1, 1'b0);
        chk("swap.ra", 16'(bus.regAdrA_o), 16'd2);
        chk("swap.rb", 16'(bus.regAdrB_o), 16'd1);
        chk("swap.bo", 16'(bus.byteOp_o), 16'd0);
        issue("rld", 16'h8000, 5'd7, 1'b1, 1'b0);
        issue("cbr", 16'h2000, 5'd2, 1'b1, 1'b0);
        issue("lbr", 16'h0000, 5'd3, 1'b1, 1'b0);
        issue("ald", 16'h5000, 5'd5, 1'b1, 1'b0);
        issue("ast", 16'h5400, 5'd6, 1'b1, 1'b0);
        issue("trp", 16'h5800, 5'd11, 1'b1, 1'b0);
        issue("imm", 16'h6000, 5'd9, 1'b1, 1'b0);
        issue("rst", 16'hC07F, 5'd8, 1'b1, 1'b0);
        chk("rst.ra", 16'(bus.regAdrA_o), 16'd7);
        chk("rst.rb", 16'(bus.regAdrB_o), 16'd7);
        chk("rst.bo", 16'(bus.byteOp_o), 16'd1);

        // back-pressure with a bundle held
        bus.dec_ready_i  = 1'b0;
        bus.inst_i       = 16'h4003;
        bus.inst_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #0;
            chk("bp.rdy", 16'(bus.inst_ready_o), 16'd0);
            @(posedge clk);
            #1;
            chk("bp.inst", bus.inst_o, 16'hC07F);
            chk("bp.vld", 16'(bus.dec_valid_o), 16'd1);
        end
        bus.dec_ready_i = 1'b1;
        issue("bp.rel", 16'h4003, 5'd4, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("bp.drain", 16'(bus.dec_valid_o), 16'd0);

        // CEX EQ true, t=2 f=1
        bus.flags_i = 4'b0010;
        issue("cex1", 16'h5C11, 5'd12, 1'b1, 1'b1);
        issue("cex1.a", 16'h4011, 5'd4, 1'b1, 1'b1);
        issue("cex1.b", 16'h4012, 5'd4, 1'b1, 1'b1);
        issue("cex1.c", 16'h4013, 5'd4, 1'b0, 1'b0);
        issue("cex1.d", 16'h4014, 5'd4, 1'b1, 1'b0);

        // CEX NE false, t=1 f=2
        issue("cex2", 16'h5C4A, 5'd12, 1'b1, 1'b1);
        issue("cex2.a", 16'h4021, 5'd4, 1'b0, 1'b1);
        issue("cex2.b", 16'h4022, 5'd4, 1'b1, 1'b1);
        issue("cex2.c", 16'h4023, 5'd4, 1'b1, 1'b0);

        // empty CEX leaves FSM idle
        issue("cex0", 16'h5C00, 5'd12, 1'b1, 1'b0);
        issue("cex0.a", 16'h4031, 5'd4, 1'b1, 1'b0);

        // nested CEX FA t=3 f=3 inside TR t=3 must not reload
        issue("nest", 16'h5F98, 5'd12, 1'b1, 1'b1);
        issue("nest.a", 16'h4041, 5'd4, 1'b1, 1'b1);
        issue("nest.b", 16'h5FDB, 5'd12, 1'b0, 1'b1);
        issue("nest.c", 16'h4043, 5'd4, 1'b1, 1'b0);
        issue("nest.d", 16'h4044, 5'd4, 1'b1, 1'b0);

        // LT with N=1 V=0 is true
        bus.flags_i = 4'b0100;
        issue("lt", 16'h5EC8, 5'd12, 1'b1, 1'b1);
        issue("lt.a", 16'h4051, 5'd4, 1'b1, 1'b0);

        // flush with a concurrent accept mid-block
        issue("fl", 16'h5F98, 5'd12, 1'b1, 1'b1);
        issue("fl.a", 16'h4061, 5'd4, 1'b1, 1'b1);
        bus.inst_i       = 16'h4062;
        bus.inst_valid_i = 1'b1;
        bus.flush_i      = 1'b1;
        @(posedge clk);
        #1;
        bus.inst_valid_i = 1'b0;
        bus.flush_i      = 1'b0;
        chk("fl.vld", 16'(bus.dec_valid_o), 16'd0);
        chk("fl.cex", 16'(bus.cexActive_o), 16'd0);
        issue("fl.b", 16'h4063, 5'd4, 1'b1, 1'b0);

        // reset mid-block abandons it
        issue("rb", 16'h5F98, 5'd12, 1'b1, 1'b1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rb.vld", 16'(bus.dec_valid_o), 16'd0);
        chk("rb.cex", 16'(bus.cexActive_o), 16'd0);
        issue("rb.a", 16'h4071, 5'd4, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
